// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO built around an external 64x8 dual-port RAM.
// Port A writes at the write pointer, port B reads at the read pointer with a
// one-cycle registered read latency. A 2-entry skid buffer behind the RAM hides
// that latency so the block moves one word per cycle in and out.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W:0]   o_count,
    output logic [DATA_W-1:0] o_ram_data_a,
    output logic [ADDR_W-1:0] o_ram_addr_a,
    output logic              o_ram_we_a,
    output logic [DATA_W-1:0] o_ram_data_b,
    output logic [ADDR_W-1:0] o_ram_addr_b,
    output logic              o_ram_we_b,
    input  logic [DATA_W-1:0] i_ram_q_b
);

    // RAM occupancy value that means "every RAM location holds a word".
    localparam logic [ADDR_W:0] OCC_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_ram_occ;
    logic              r_pending;
    logic [1:0]        r_buf_occ;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic              r_in_ready;

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_committed;
    logic [ADDR_W:0]   w_ram_occ_next;
    logic [1:0]        w_occ_shift;
    logic [DATA_W-1:0] w_buf0_shift;
    logic [DATA_W-1:0] w_buf0_next;
    logic [DATA_W-1:0] w_buf1_next;
    logic [1:0]        w_buf_occ_next;

    // A word offered during a clear is dropped, so it must not reach the RAM either.
    assign w_push = i_in_valid & r_in_ready & ~i_clr;
    assign w_pop  = (r_buf_occ != 2'd0) & i_out_ready;

    // Words already headed for the skid buffer: resident entries plus one in flight.
    assign w_committed = {1'b0, r_buf_occ} + {2'b00, r_pending};

    // Read the RAM only if the skid buffer will still have room when the data lands.
    assign w_issue = (r_ram_occ != '0) && (w_committed <= ({2'b00, w_pop} + 3'd1));

    assign w_ram_occ_next = r_ram_occ + {{ADDR_W{1'b0}}, w_push}
                                      - {{ADDR_W{1'b0}}, w_issue};

    // Skid buffer after the consumer takes the head entry.
    assign w_occ_shift  = r_buf_occ - {1'b0, w_pop};
    assign w_buf0_shift = w_pop ? r_buf1 : r_buf0;

    // Returning RAM data fills the lowest free skid entry after the pop shift.
    always_comb begin
        w_buf0_next    = w_buf0_shift;
        w_buf1_next    = r_buf1;
        w_buf_occ_next = w_occ_shift;
        if (r_pending) begin
            if (w_occ_shift == 2'd0) begin
                w_buf0_next = i_ram_q_b;
            end else begin
                w_buf1_next = i_ram_q_b;
            end
            w_buf_occ_next = w_occ_shift + 2'd1;
        end
    end

    // Pointer, occupancy and skid-buffer state; clear sits just below reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_occ  <= '0;
            r_pending  <= 1'b0;
            r_buf_occ  <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_in_ready <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_occ  <= '0;
            r_pending  <= 1'b0;
            r_buf_occ  <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_occ  <= w_ram_occ_next;
            r_pending  <= w_issue;
            r_buf_occ  <= w_buf_occ_next;
            r_buf0     <= w_buf0_next;
            r_buf1     <= w_buf1_next;
            // Ready follows next-cycle RAM room; a same-cycle issue gives no bypass.
            r_in_ready <= (w_ram_occ_next < OCC_FULL);
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = (r_buf_occ != 2'd0);
    assign o_out_data   = r_buf0;
    assign o_count      = r_ram_occ + {{ADDR_W{1'b0}}, r_pending}
                                    + {{(ADDR_W-1){1'b0}}, r_buf_occ};

    assign o_ram_data_a = i_in_data;
    assign o_ram_addr_a = r_wr_ptr;
    assign o_ram_we_a   = w_push;
    assign o_ram_data_b = '0;
    assign o_ram_addr_b = r_rd_ptr;
    assign o_ram_we_b   = 1'b0;

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that owns the 64×8 dual-port RAM and turns it into a valid/ready stream buffer. Port A of the RAM is used only for writes at the write pointer; port B only for reads at the read pointer. A 2-entry output skid buffer absorbs the RAM's 1-cycle registered read latency so the block sustains one word per cycle in and out. It sits directly upstream of the RAM instance and between a producer and a consumer stage.

## Interface
- DATA_W, 8, word width; must match the RAM data width
- ADDR_W, 6, RAM address width; RAM depth DEPTH = 2**ADDR_W = 64
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear; drops all stored words
- in_data  in  DATA_W  producer word
- in_valid  in  1  producer word valid
- in_ready  out  1  block can accept a word (registered)
- out_data  out  DATA_W  head-of-FIFO word (buffer entry 0)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- count  out  ADDR_W+1  words held: ram_occ + pending + buf_occ, range 0..DEPTH+2
- ram_data_a  out  DATA_W  equals in_data
- ram_addr_a  out  ADDR_W  write pointer
- ram_we_a  out  1  push = in_valid & in_ready
- ram_data_b  out  DATA_W  tied 0
- ram_addr_b  out  ADDR_W  read pointer
- ram_we_b  out  1  tied 0
- ram_q_b  in  DATA_W  RAM port-B read data, valid in the cycle after a read issue

## Operation
- State: wr_ptr, rd_ptr (ADDR_W bits, wrap modulo DEPTH), ram_occ (0..DEPTH), pending (1 bit), buf_occ (0..2), skid buffer entries buf0 (head) and buf1, in_ready register.
- push = in_valid & in_ready. On push: RAM writes in_data at wr_ptr; wr_ptr+1.
- pop = out_valid & out_ready. On pop: buf0 is removed and buf1, if valid, shifts into buf0.
- issue (read of rd_ptr on port B) is asserted in cycle t iff ram_occ > 0 and (buf_occ + pending − pop) ≤ 1. On issue: rd_ptr+1; pending is set for the next cycle.
- In a cycle with pending = 1, ram_q_b is written into the lowest free skid entry after the pop shift.
- ram_occ_next = ram_occ + push − issue.
- in_ready_next = (ram_occ_next < DEPTH). There is no bypass: in_ready is not raised in the same cycle by an issue.
- out_valid = buf_occ ≠ 0; out_data = buf0.
- No port collision: a write requires ram_occ < DEPTH and a read requires ram_occ > 0, so wr_ptr ≠ rd_ptr whenever both are active in a cycle.
- clr (priority below rst_n, above all else): pointers, ram_occ, pending, buf_occ ← 0; in_ready ← 1. Any push or pop in that cycle is discarded. The RAM contents are not cleared.
- Reset: the same state as clr, except in_ready ← 0. in_ready rises at the first clk edge after rst_n deasserts. Reset mid-stream drops all data.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, count 0, ram_we_a 0, ram_addr_a 0, ram_addr_b 0.
- First-word latency into an empty FIFO: a word pushed at edge E0 is issued in the cycle after E0, returns on ram_q_b after E1, and is captured at E2. out_valid is high in the cycle after E2, which is 3 cycles after acceptance.
- Steady state with in_valid = out_ready = 1: one push and one pop per cycle with no bubbles.
- Full: ram_occ = DEPTH gives in_ready = 0. The maximum count is DEPTH+2 = 66 (RAM plus skid buffer full, pending 0).
- Empty: count = 0 gives out_valid = 0 and no issue.
- Simultaneous push and pop: count is unchanged.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 back-to-back with out_ready = 1. Required: out_valid rises 3 cycles after the first accept, and the output is 0x11, 0x22, 0x33 on consecutive cycles.
- out_ready = 0, push 0x00..0x45 (70 words). Required: 66 words accepted, in_ready drops with count = 66, and the remaining 4 words are not accepted. Then drain with out_ready = 1: all 66 words come out in order, and in_ready returns to 1 one cycle after the first RAM issue.
- Continuous stream of 200 incrementing words (mod 256) with out_ready = 1. Required: wr_ptr and rd_ptr wrap past 63 with no loss or duplication and throughput of 1 word/cycle.
- Random out_ready (50%) with random in_valid (70%), 1000 words. Required: output matches a reference queue, count always equals pushes − pops, and ram_we_b stays 0.
- With count = 10, assert clr for one cycle together with in_valid = 1. Required: the next cycle has count = 0, out_valid = 0, in_ready = 1, and the word presented in the clr cycle is never output.
- Pull rst_n low asynchronously mid-stream between clock edges. Required: all outputs go to their reset values immediately, and after release the FIFO accepts and returns 0xA5 correctly.
